// File: rtl/minisys_io_pkg.sv
// minisys_io_pkg: shared Minisys I/O addresses, CTC register map and bit positions
package minisys_io_pkg;

    localparam logic [31:0] CTC_BASE_ADDR = 32'hFFFF_FC20;

    typedef enum logic [1:0] {
        CTC_MODE0 = 2'd0,
        CTC_MODE1 = 2'd1,
        CTC_INIT0 = 2'd2,
        CTC_INIT1 = 2'd3
    } ctc_reg_e;

    typedef enum logic {
        CTC_TIMING   = 1'b0,
        CTC_COUNTING = 1'b1
    } ctc_mode_e;

    localparam int MODE_BIT   = 0;
    localparam int REPEAT_BIT = 1;
    localparam int RUN_BIT    = 15;
    localparam int TC_BIT     = 0;

    function automatic logic [15:0] ctc_status(input logic run, input logic tc);
        logic [15:0] s;
        s = '0;
        s[RUN_BIT] = run;
        s[TC_BIT] = tc;
        return s;
    endfunction

endpackage

// File: rtl/ctc_channel.sv
// ctc_channel: one counter/timer channel with mode/init/count/status, pulse synchronizer and terminal logic
module ctc_channel
    import minisys_io_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mode_we_i,
    input  logic        init_we_i,
    input  logic        stat_rd_i,
    input  logic [15:0] wdata_i,
    input  logic        pulse_i,
    output logic [15:0] status_o,
    output logic [15:0] count_o,
    output logic        out_n_o
);

    logic [1:0]             mode_q, mode_d;
    logic [CNT_WIDTH-1:0]   init_q, init_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   run_q, run_d;
    logic                   tc_q, tc_d;
    logic                   out_n_q, out_n_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_WIDTH-1:0]   wval;
    logic                   pulse_rise, dec, term, rep;

    assign wval       = CNT_WIDTH'(wdata_i);
    assign pulse_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign rep        = mode_q[REPEAT_BIT];
    assign dec        = run_q & ((ctc_mode_e'(mode_q[MODE_BIT]) == CTC_COUNTING) ? pulse_rise : 1'b1);
    assign term       = dec & (count_q == CNT_WIDTH'(1));

    assign status_o = ctc_status(run_q, tc_q);
    assign count_o  = 16'(count_q);
    assign out_n_o  = out_n_q;

    // Synchronize the asynchronous pulse input and keep the previous sample for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, pulse_i});
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Next state: a bus write always overrides a coincident decrement or terminal event
    always_comb begin
        mode_d  = mode_we_i ? wdata_i[1:0] : mode_q;
        init_d  = init_we_i ? wval : init_q;
        count_d = mode_we_i ? '0 :
                  init_we_i ? wval :
                  term ? (rep ? init_q : '0) :
                  dec ? count_q - CNT_WIDTH'(1) : count_q;
        run_d   = mode_we_i ? 1'b0 :
                  init_we_i ? (wval != '0) :
                  term ? rep : run_q;
        tc_d    = mode_we_i ? 1'b0 :
                  (init_we_i && wval != '0) ? 1'b0 :
                  (term && !init_we_i) ? 1'b1 :
                  stat_rd_i ? 1'b0 : tc_q;
        out_n_d = ~(term & ~mode_we_i & ~init_we_i);
    end

    // Channel state registers; the terminal pulse output idles high
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q  <= '0;
            init_q  <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
            tc_q    <= 1'b0;
            out_n_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            init_q  <= init_d;
            count_q <= count_d;
            run_q   <= run_d;
            tc_q    <= tc_d;
            out_n_q <= out_n_d;
        end
    end

endmodule

// File: rtl/ctc_timer.sv
// ctc_timer: two-channel counter/timer on the Minisys I/O bus; address decode and read mux only
module ctc_timer
    import minisys_io_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctc_cs,
    input  logic        ctc_read,
    input  logic        ctc_write,
    input  logic [2:0]  ctc_addr,
    input  logic [15:0] ctc_wdata,
    output logic [15:0] ctc_rdata,
    input  logic        pulse0_in,
    input  logic        pulse1_in,
    output logic        ctc_out0,
    output logic        ctc_out1
);

    ctc_reg_e    sel;
    logic        wr, rd;
    logic        unused_addr0;
    logic [15:0] st0, st1, cnt0, cnt1;

    assign sel          = ctc_reg_e'(ctc_addr[2:1]);
    assign unused_addr0 = ctc_addr[0];
    assign wr           = ctc_cs & ctc_write;
    assign rd           = ctc_cs & ctc_read;

    ctc_channel #(.CNT_WIDTH(CNT_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_ch0 (
        .clk_i     (clock),
        .rst_i     (reset),
        .mode_we_i (wr && sel == CTC_MODE0),
        .init_we_i (wr && sel == CTC_INIT0),
        .stat_rd_i (rd && sel == CTC_MODE0),
        .wdata_i   (ctc_wdata),
        .pulse_i   (pulse0_in),
        .status_o  (st0),
        .count_o   (cnt0),
        .out_n_o   (ctc_out0)
    );

    ctc_channel #(.CNT_WIDTH(CNT_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_ch1 (
        .clk_i     (clock),
        .rst_i     (reset),
        .mode_we_i (wr && sel == CTC_MODE1),
        .init_we_i (wr && sel == CTC_INIT1),
        .stat_rd_i (rd && sel == CTC_MODE1),
        .wdata_i   (ctc_wdata),
        .pulse_i   (pulse1_in),
        .status_o  (st1),
        .count_o   (cnt1),
        .out_n_o   (ctc_out1)
    );

    // Combinational read mux; returns pre-write register values during a coincident write
    always_comb begin
        ctc_rdata = !rd ? 16'h0000 :
                    sel == CTC_MODE0 ? st0 :
                    sel == CTC_MODE1 ? st1 :
                    sel == CTC_INIT0 ? cnt0 : cnt1;
    end

endmodule

// File: tb/tb_ctc_timer.sv
// tb_ctc_timer: directed scoreboard bench for the two-channel counter/timer
module tb_ctc_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctc_cs = 1'b0, ctc_read = 1'b0, ctc_write = 1'b0;
    logic [2:0]  ctc_addr = '0;
    logic [15:0] ctc_wdata = '0;
    logic [15:0] ctc_rdata;
    logic        pulse0_in = 1'b0, pulse1_in = 1'b0;
    logic        ctc_out0, ctc_out1;

    int checks = 0;
    int errs = 0;
    int cyc = 0;
    int k;

    logic [15:0] rd_q[$];
    string       rn_q[$];
    int          p0_q[$];
    int          p1_q[$];
    logic [15:0] e_rd;
    string       e_nm;
    int          e_cyc;

    ctc_timer dut (
        .clock     (clock),
        .reset     (reset),
        .ctc_cs    (ctc_cs),
        .ctc_read  (ctc_read),
        .ctc_write (ctc_write),
        .ctc_addr  (ctc_addr),
        .ctc_wdata (ctc_wdata),
        .ctc_rdata (ctc_rdata),
        .pulse0_in (pulse0_in),
        .pulse1_in (pulse1_in),
        .ctc_out0  (ctc_out0),
        .ctc_out1  (ctc_out1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents read data or a terminal pulse
    always @(negedge clock) begin
        if (ctc_cs && ctc_read) begin
            checks++;
            if (rd_q.size() == 0) begin
                errs++;
                $display("FAIL rd_unexpected: got %h with no expected value", ctc_rdata);
            end else begin
                e_rd = rd_q.pop_front();
                e_nm = rn_q.pop_front();
                if (ctc_rdata !== e_rd) begin
                    errs++;
                    $display("FAIL %s: got %h expected %h (cyc %0d)", e_nm, ctc_rdata, e_rd, cyc);
                end
            end
        end
        if (ctc_out0 !== 1'b1) begin
            checks++;
            if (p0_q.size() == 0) begin
                errs++;
                $display("FAIL out0_unexpected: low at cyc %0d, no pulse expected", cyc);
            end else begin
                e_cyc = p0_q.pop_front();
                if (cyc != e_cyc) begin
                    errs++;
                    $display("FAIL out0_timing: low at cyc %0d expected cyc %0d", cyc, e_cyc);
                end
            end
        end
        if (ctc_out1 !== 1'b1) begin
            checks++;
            if (p1_q.size() == 0) begin
                errs++;
                $display("FAIL out1_unexpected: low at cyc %0d, no pulse expected", cyc);
            end else begin
                e_cyc = p1_q.pop_front();
                if (cyc != e_cyc) begin
                    errs++;
                    $display("FAIL out1_timing: low at cyc %0d expected cyc %0d", cyc, e_cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        ctc_cs = 1'b1;
        ctc_write = 1'b1;
        ctc_addr = a;
        ctc_wdata = d;
        tick();
        ctc_cs = 1'b0;
        ctc_write = 1'b0;
    endtask

    task automatic rd(input string n, input logic [2:0] a, input logic [15:0] e);
        rd_q.push_back(e);
        rn_q.push_back(n);
        ctc_cs = 1'b1;
        ctc_read = 1'b1;
        ctc_addr = a;
        tick();
        ctc_cs = 1'b0;
        ctc_read = 1'b0;
    endtask

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_out0", {15'b0, ctc_out0}, 16'h0001);
        check("rst_out1", {15'b0, ctc_out1}, 16'h0001);
        reset = 1'b0;
        tick();
        rd("rst_st0", 3'd0, 16'h0000);
        rd("rst_st1", 3'd2, 16'h0000);
        rd("rst_cnt0", 3'd4, 16'h0000);
        rd("rst_cnt1", 3'd6, 16'h0000);
        ctc_read = 1'b1;
        ctc_addr = 3'd4;
        #1;
        check("rdata_no_cs", ctc_rdata, 16'h0000);
        ctc_read = 1'b0;
        tick();

        // one-shot timing, N=5
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'd5);
        p0_q.push_back(cyc + 5);
        repeat (6) tick();
        rd("oneshot_st0", 3'd0, 16'h0001);
        rd("oneshot_st0_clr", 3'd0, 16'h0000);
        rd("oneshot_cnt0", 3'd4, 16'h0000);

        // repeat timing, N=3, ten periods
        wr(3'd2, 16'h0002);
        wr(3'd6, 16'd3);
        k = cyc;
        for (int i = 1; i <= 10; i++) p1_q.push_back(k + 3 * i);
        repeat (3) tick();
        rd("repeat_st1", 3'd2, 16'h8001);
        repeat (27) tick();
        wr(3'd2, 16'h0000);
        rd("stop_st1", 3'd2, 16'h0000);

        // counting mode, two edges ten clocks apart
        wr(3'd0, 16'h0001);
        wr(3'd4, 16'd2);
        k = cyc;
        pulse0_in = 1'b1;
        repeat (4) tick();
        rd("count_after_edge1", 3'd4, 16'd1);
        pulse0_in = 1'b0;
        repeat (5) tick();
        pulse0_in = 1'b1;
        p0_q.push_back(k + 10 + 3);
        repeat (6) tick();
        pulse0_in = 1'b0;
        repeat (2) tick();
        rd("count_done_st0", 3'd0, 16'h0001);

        // counting mode, single edge: no terminal
        wr(3'd4, 16'd2);
        pulse0_in = 1'b1;
        repeat (10) tick();
        pulse0_in = 1'b0;
        repeat (3) tick();
        rd("single_edge_cnt0", 3'd4, 16'd1);
        rd("single_edge_st0", 3'd0, 16'h8000);

        // init write coincident with terminal event; status read coincident with terminal event
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'd3);
        repeat (2) tick();
        wr(3'd4, 16'd7);
        k = cyc;
        p0_q.push_back(k + 7);
        rd("write_wins_cnt0", 3'd4, 16'd7);
        repeat (5) tick();
        rd("rd_at_term_st0", 3'd0, 16'h8000);
        rd("tc_set_wins", 3'd0, 16'h0001);

        // reset mid-count
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'd100);
        wr(3'd2, 16'h0002);
        wr(3'd6, 16'd2);
        k = cyc;
        for (int i = 1; i <= 28; i++) p1_q.push_back(k + 2 * i);
        repeat (58) tick();
        check("out1_low_pre_reset", {15'b0, ctc_out1}, 16'h0000);
        reset = 1'b1;
        #1;
        check("async_rst_out0", {15'b0, ctc_out0}, 16'h0001);
        check("async_rst_out1", {15'b0, ctc_out1}, 16'h0001);
        rd("rst_mid_st0", 3'd0, 16'h0000);
        rd("rst_mid_st1", 3'd2, 16'h0000);
        rd("rst_mid_cnt0", 3'd4, 16'h0000);
        rd("rst_mid_cnt1", 3'd6, 16'h0000);
        reset = 1'b0;
        tick();

        // init of zero never runs
        wr(3'd4, 16'd0);
        repeat (5) tick();
        rd("init0_st0", 3'd0, 16'h0000);
        rd("init0_cnt0", 3'd4, 16'h0000);
        repeat (4) tick();

        foreach (rd_q[i]) begin
            checks++;
            errs++;
            $display("FAIL rd_missing: %s expected %h never sampled", rn_q[i], rd_q[i]);
        end
        foreach (p0_q[i]) begin
            checks++;
            errs++;
            $display("FAIL out0_missing: got no pulse, expected at cyc %0d", p0_q[i]);
        end
        foreach (p1_q[i]) begin
            checks++;
            errs++;
            $display("FAIL out1_missing: got no pulse, expected at cyc %0d", p1_q[i]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
